// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcodes, FSM state encoding and result-entry layout for
//             the ALU command sequencer and its result FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

    // Opcodes implemented by the downstream combinational ALU
    localparam logic [2:0] OP_XOR = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;

    // Result entry: 4b data + 3b opcode + 4 flag bits
    localparam int RES_W = 11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] code;
        logic       carry;
        logic       sign;
        logic       zero;
        logic       err;
    } res_entry_t;

    function automatic logic op_legal(input logic [2:0] code);
        return (code == OP_XOR) || (code == OP_ADD) ||
               (code == OP_AND) || (code == OP_SUB);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_res_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : alu_res_fifo
//  Purpose  : Show-ahead synchronous FIFO holding ALU result entries.
//  Ports    : clk, rst          clock, synchronous active-high reset
//             i_push, i_din     write strobe and entry (ignored when full)
//             i_pop             read strobe (ignored when empty)
//             o_dout            head entry, zero while empty
//             o_full, o_empty   occupancy flags from the internal count
//  Revision : 1.0  initial release
// ============================================================================
module alu_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);

    // Head is gated to zero while empty so stale entries never show.
    assign o_dout  = o_empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        w_do_push = i_push && !o_full;
        w_do_pop  = i_pop  && !o_empty;
        mem_d     = mem_q;
        if (w_do_push) begin
            mem_d[wr_ptr_q] = i_din;
        end
        // Pointers wrap naturally because DEPTH is a power of two
        wr_ptr_d = wr_ptr_q + PW'(w_do_push);
        rd_ptr_d = rd_ptr_q + PW'(w_do_pop);
        count_d  = count_q + CW'(w_do_push) - CW'(w_do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_sequencer
//  Purpose  : Accepts valid/ready ALU commands, drives the combinational ALU
//             from registers, samples its result one cycle later and queues
//             {data, code, flags, err} in a show-ahead result FIFO.
//  Ports    : clk, rst                     clock, synchronous active-high reset
//             cmd_valid/ready/code/a/b     command stream
//             alu_code/a/b                 registered ALU inputs
//             alu_out/carry/sign/zero      ALU outputs, sampled in WAIT
//             res_valid/ready/data/code/
//             res_carry/sign/zero/err      result stream (FIFO head)
//             op_count                     accepted-command counter, wraps
//  Revision : 1.0  initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_code,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [2:0] alu_code,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_sign,
    input  logic       alu_zero,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic [2:0] res_code,
    output logic       res_carry,
    output logic       res_sign,
    output logic       res_zero,
    output logic       res_err,
    output logic [7:0] op_count
);

    state_e     state_q,    state_d;
    logic [2:0] alu_code_q, alu_code_d;
    logic [3:0] alu_a_q,    alu_a_d;
    logic [3:0] alu_b_q,    alu_b_d;
    logic       err_q,      err_d;
    logic [2:0] err_code_q, err_code_d;
    logic [7:0] op_count_q, op_count_d;

    logic       w_push;
    res_entry_t w_push_entry;
    res_entry_t w_head;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic       w_handshake;

    // Depends only on state and the registered full flag
    assign cmd_ready   = (state_q == ST_IDLE) && !w_fifo_full;
    assign w_handshake = cmd_valid && cmd_ready;

    always_comb begin
        state_d      = state_q;
        alu_code_d   = alu_code_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        err_d        = err_q;
        err_code_d   = err_code_q;
        op_count_d   = op_count_q;
        w_push       = 1'b0;
        w_push_entry = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_handshake) begin
                    op_count_d = op_count_q + 8'd1;
                    state_d    = ST_WAIT;
                    if (op_legal(cmd_code)) begin
                        alu_code_d = cmd_code;
                        alu_a_d    = cmd_a;
                        alu_b_d    = cmd_b;
                        err_d      = 1'b0;
                    end else begin
                        // ALU inputs are left alone; only the bad code is kept
                        err_d      = 1'b1;
                        err_code_d = cmd_code;
                    end
                end
            end
            ST_WAIT: begin
                w_push  = 1'b1;
                state_d = ST_IDLE;
                if (err_q) begin
                    w_push_entry.code = err_code_q;
                    w_push_entry.err  = 1'b1;
                end else begin
                    w_push_entry.data  = alu_out;
                    w_push_entry.code  = alu_code_q;
                    w_push_entry.carry = alu_carry;
                    w_push_entry.sign  = alu_sign;
                    w_push_entry.zero  = alu_zero;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            alu_code_q <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            alu_code_q <= alu_code_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            op_count_q <= op_count_d;
        end
    end

    alu_res_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (res_ready),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign alu_code  = alu_code_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign op_count  = op_count_q;

    assign res_valid = !w_fifo_empty;
    assign res_data  = w_head.data;
    assign res_code  = w_head.code;
    assign res_carry = w_head.carry;
    assign res_sign  = w_head.sign;
    assign res_zero  = w_head.zero;
    assign res_err   = w_head.err;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_sequencer
//  Purpose  : Self-checking bench for alu_cmd_sequencer with a behavioural
//             ALU and a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [2:0] cmd_code;
    logic [3:0] cmd_a, cmd_b;
    logic [2:0] alu_code;
    logic [3:0] alu_a, alu_b, alu_out;
    logic       alu_carry, alu_sign, alu_zero;
    logic       res_valid, res_ready;
    logic [3:0] res_data;
    logic [2:0] res_code;
    logic       res_carry, res_sign, res_zero, res_err;
    logic [7:0] op_count;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_code  (alu_code),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .alu_sign  (alu_sign),
        .alu_zero  (alu_zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_code  (res_code),
        .res_carry (res_carry),
        .res_sign  (res_sign),
        .res_zero  (res_zero),
        .res_err   (res_err),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stand-in
    logic [4:0] alu_t;
    always_comb begin
        alu_t    = '0;
        alu_sign = 1'b0;
        case (alu_code)
            3'b001: alu_t = {1'b0, alu_a ^ alu_b};
            3'b010: alu_t = {1'b0, alu_a} + {1'b0, alu_b};
            3'b011: alu_t = {1'b0, alu_a & alu_b};
            3'b100: begin
                if (alu_b > alu_a) begin
                    alu_t    = {1'b0, alu_b - alu_a};
                    alu_sign = 1'b1;
                end else begin
                    alu_t = {1'b0, alu_a - alu_b};
                end
            end
            default: alu_t = '0;
        endcase
        alu_out   = alu_t[3:0];
        alu_carry = alu_t[4];
        alu_zero  = (alu_t == 5'd0);
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [3:0] d;
        logic [2:0] c;
        logic       cy, sg, z, e;
    } ent_t;

    ent_t       mq[$];
    ent_t       pend;
    bit         busy;
    int         opc;
    logic [2:0] m_code;
    logic [3:0] m_a, m_b;

    int n_chk  = 0;
    int n_fail = 0;
    int dut_pops = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t ref_ent(input logic [2:0] c, input int a, input int b);
        ent_t e;
        int   r;
        e   = '0;
        e.c = c;
        r   = 0;
        case (c)
            3'd1: begin r = a ^ b; e.d = r[3:0]; e.z = (r == 0); end
            3'd2: begin r = a + b; e.d = r[3:0]; e.cy = (r >= 16); e.z = (r == 0); end
            3'd3: begin r = a & b; e.d = r[3:0]; e.z = (r == 0); end
            3'd4: begin
                r    = a - b;
                e.sg = (r < 0);
                if (r < 0) r = -r;
                e.d  = r[3:0];
                e.z  = (r == 0);
            end
            default: e.e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic bit is_legal(input logic [2:0] c);
        return (c >= 3'd1) && (c <= 3'd4);
    endfunction

    task automatic model_reset();
        mq.delete();
        busy   = 1'b0;
        opc    = 0;
        m_code = '0;
        m_a    = '0;
        m_b    = '0;
    endtask

    // One clock cycle: check current outputs, drive inputs, advance model
    task automatic step(input bit v, input logic [2:0] c, input logic [3:0] a,
                        input logic [3:0] b, input bit rr, input bit r, output bit hs_o);
        bit er;
        bit pop;
        @(negedge clk);
        er = !busy && (mq.size() < DEPTH);
        chk("cmd_ready", cmd_ready, er);
        chk("res_valid", res_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            chk("res_data",  res_data,  mq[0].d);
            chk("res_code",  res_code,  mq[0].c);
            chk("res_carry", res_carry, mq[0].cy);
            chk("res_sign",  res_sign,  mq[0].sg);
            chk("res_zero",  res_zero,  mq[0].z);
            chk("res_err",   res_err,   mq[0].e);
        end
        chk("op_count", op_count, opc % 256);
        chk("alu_code", alu_code, m_code);
        chk("alu_a",    alu_a,    m_a);
        chk("alu_b",    alu_b,    m_b);

        rst       = r;
        cmd_valid = v && !r;
        cmd_code  = c;
        cmd_a     = a;
        cmd_b     = b;
        res_ready = rr;
        if (res_valid && rr) dut_pops++;

        hs_o = 1'b0;
        if (r) begin
            model_reset();
        end else begin
            hs_o = v && er;
            pop  = rr && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            if (busy) mq.push_back(pend);
            busy = hs_o;
            if (hs_o) begin
                opc++;
                if (is_legal(c)) begin
                    m_code = c;
                    m_a    = a;
                    m_b    = b;
                end
                pend = ref_ent(c, int'(a), int'(b));
            end
        end
    endtask

    task automatic idle(input bit rr);
        bit hs;
        step(1'b0, 3'd0, 4'd0, 4'd0, rr, 1'b0, hs);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit         hs;
        int         hsn;
        logic [2:0] rc;
        logic [3:0] ra, rb;
        logic [2:0] fc [5];
        logic [3:0] fa [5];
        logic [3:0] fb [5];

        rst = 1'b1; cmd_valid = 1'b0; cmd_code = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // ADD 9+8 with result timing
        step(1'b1, 3'b010, 4'd9, 4'd8, 1'b0, 1'b0, hs);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_res_data", res_data, 4'd0);
        idle(1'b0);
        chk("n1_ready", cmd_ready, 1'b0);
        chk("n1_valid", res_valid, 1'b0);
        idle(1'b1);
        chk("add_valid", res_valid, 1'b1);
        chk("add_data",  res_data,  4'd1);
        chk("add_carry", res_carry, 1'b1);
        chk("add_sign",  res_sign,  1'b0);
        chk("add_zero",  res_zero,  1'b0);
        chk("add_code",  res_code,  3'b010);
        chk("add_cnt",   op_count,  8'd1);

        // SUB 3-7 then 5-5
        step(1'b1, 3'b100, 4'd3, 4'd7, 1'b1, 1'b0, hs);
        idle(1'b1);
        step(1'b1, 3'b100, 4'd5, 4'd5, 1'b1, 1'b0, hs);
        chk("sub1_data", res_data, 4'd4);
        chk("sub1_sign", res_sign, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("sub2_data", res_data, 4'd0);
        chk("sub2_zero", res_zero, 1'b1);
        chk("sub2_sign", res_sign, 1'b0);

        // Illegal code 110
        step(1'b1, 3'b110, 4'hF, 4'hF, 1'b1, 1'b0, hs);
        idle(1'b1);
        idle(1'b1);
        chk("ill_err",   res_err,  1'b1);
        chk("ill_data",  res_data, 4'd0);
        chk("ill_code",  res_code, 3'b110);
        chk("ill_alu",   alu_code, 3'b100);
        chk("ill_cnt",   op_count, 8'd4);
        idle(1'b1);

        // Fill the FIFO with res_ready low
        fc[0] = 3'b001; fa[0] = 4'hA; fb[0] = 4'h5;
        fc[1] = 3'b011; fa[1] = 4'hC; fb[1] = 4'h6;
        fc[2] = 3'b010; fa[2] = 4'h1; fb[2] = 4'h1;
        fc[3] = 3'b010; fa[3] = 4'h2; fb[3] = 4'h2;
        fc[4] = 3'b010; fa[4] = 4'h3; fb[4] = 4'h3;
        hsn = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, fc[hsn], fa[hsn], fb[hsn], 1'b0, 1'b0, hs);
            if (hs && hsn < 4) hsn++;
        end
        chk("full_ready", cmd_ready, 1'b0);
        step(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b0, hs);
        chk("full_head0", res_data, 4'hF);
        idle(1'b0);
        chk("reopen_ready", cmd_ready, 1'b1);
        chk("full_head1", res_data, 4'h4);
        repeat (8) idle(1'b1);

        // Reset during WAIT
        step(1'b1, 3'b010, 4'd1, 4'd2, 1'b1, 1'b0, hs);
        step(1'b0, 3'd0, 4'd0, 4'd0, 1'b1, 1'b1, hs);
        idle(1'b1);
        chk("wrst_valid", res_valid, 1'b0);
        chk("wrst_code",  alu_code,  3'd0);
        chk("wrst_a",     alu_a,     4'd0);
        chk("wrst_b",     alu_b,     4'd0);
        chk("wrst_cnt",   op_count,  8'd0);
        idle(1'b1);
        idle(1'b1);
        chk("wrst_nopush", res_valid, 1'b0);

        // 256 commands, consumer always ready
        hsn = 0;
        dut_pops = 0;
        for (int k = 0; k < 1200 && hsn < 256; k++) begin
            rc = 3'($urandom_range(0, 7));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            step(1'b1, rc, ra, rb, 1'b1, 1'b0, hs);
            if (hs) hsn++;
        end
        repeat (4) idle(1'b1);
        if (hsn == 256) chk("op_count_wrap", op_count, 8'd0);
        else            chk("wrap_budget", hsn, 256);
        chk("no_result_lost", dut_pops, 256);

        // Random traffic with back-pressure
        for (int k = 0; k < 1500; k++) begin
            rc = 3'($urandom_range(0, 7));
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), rc, ra, rb, ($urandom_range(0, 3) != 0), 1'b0, hs);
        end
        repeat (12) idle(1'b1);
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Drives the 4-bit ALU from a valid/ready command stream and returns registered results with flags through a small result FIFO. Sits in front of the combinational ALU. Owns the ALU operand/opcode inputs, samples the ALU outputs one cycle later, and rejects opcodes the ALU does not implement. Downstream logic consumes results without touching the ALU directly.

## Interface
- `DEPTH`, default 4: result FIFO entries, power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`.
- `cmd_code`  in  3  opcode: 001 XOR, 010 ADD, 011 AND, 100 SUB.
- `cmd_a`, `cmd_b`  in  4  operands.
- `alu_code`  out  3  to ALU `Code`.
- `alu_a`, `alu_b`  out  4  to ALU `A`, `B`.
- `alu_out`  in  4  from ALU `OUT`.
- `alu_carry`, `alu_sign`, `alu_zero`  in  1  from ALU flags.
- `res_valid`  out  1  FIFO head valid.
- `res_ready`  in  1  consumer pops head when high with `res_valid`.
- `res_data`  out  4  result.
- `res_code`  out  3  opcode that produced it.
- `res_carry`, `res_sign`, `res_zero`, `res_err`  out  1  flags; `res_err` means illegal opcode.
- `op_count`  out  8  count of accepted commands, wraps 255→0.

## Operation
- States: IDLE, WAIT.
- IDLE:
  - `cmd_ready = !fifo_full`.
  - On handshake with a legal code: load `alu_code/a/b` from the command and go to WAIT.
  - On handshake with an illegal code (000, 101, 110, 111): leave `alu_*` unchanged and go to WAIT with the internal error flag set.
- WAIT:
  - `cmd_ready = 0`.
  - Push one entry at the clock edge, then return to IDLE.
  - Legal entry: {`alu_out`, `alu_code`, `alu_carry`, `alu_sign`, `alu_zero`, err=0}.
  - Illegal entry: {data=0, code=cmd code, carry=0, sign=0, zero=0, err=1}.
- Flags pass through unmodified. ALU semantics:
  - ADD: carry is bit 4 of the sum.
  - SUB: |A−B|, with sign=1 when B>A.
  - Zero: the 5-bit result is zero.
- `op_count` increments on every command handshake, legal or illegal.
- FIFO:
  - Show-ahead: the head is on `res_*` whenever `res_valid` is high.
  - `res_*` holds stable while `res_valid && !res_ready`.
  - A push and a pop in the same cycle leave the count unchanged.
  - A push never occurs when full, because `cmd_ready` is blocked in IDLE.
- Reset values:
  - State IDLE.
  - `alu_code`=000, `alu_a`=`alu_b`=0.
  - FIFO empty, so `res_valid`=0 and `res_*`=0.
  - `op_count`=0.
  - `cmd_ready` becomes 1 in the first cycle after reset deasserts.
- Reset while in WAIT discards the in-flight operation: no push occurs.

## Timing
- Handshake in cycle N.
- `alu_*` are valid from cycle N+1.
- The ALU result is sampled at the end of N+1.
- `res_valid` is high in N+2 if the FIFO was empty.
- Throughput: at most one command per 2 cycles. `cmd_ready` drops in N+1 and returns in N+2 if the FIFO is not full.
- `cmd_ready` is combinational from state and the FIFO full flag only, never from `cmd_valid`.
- `res_valid` is a registered output; it does not depend combinationally on `res_ready`.
- Full FIFO with `res_ready` high in an IDLE cycle: `cmd_ready` is still 0 that cycle and becomes 1 the next cycle.

## Structure
- Package `alu_pkg`:
  - Opcode localparams `OP_XOR`=3'b001, `OP_ADD`=3'b010, `OP_AND`=3'b011, `OP_SUB`=3'b100.
  - Function `op_legal(code)`.
  - State encoding for IDLE/WAIT.
  - Result-entry width constant (4+3+4 = 11 bits).
- Sub-module `alu_res_fifo`:
  - Parameterised by `DEPTH` and width.
  - Synchronous reset, show-ahead, with full/empty flags and a count.
- The top level holds the FSM, the `alu_*` registers, the error flag and `op_count`.
- The bench instantiates the existing ALU wired to the `alu_*` ports.

## Test plan
- Reset, then ADD A=9 B=8 → `res_valid` in N+2; data=1, carry=1, sign=0, zero=0, err=0, code=010; `op_count`=1.
- SUB A=3 B=7, then SUB A=5 B=5 → data=4 with sign=1; then data=0 with zero=1 and sign=0.
- Code 110 with A=F B=F → err=1, data=0; `alu_code` keeps its prior value; `op_count` increments.
- Hold `res_ready`=0 and issue XOR A=A B=5, AND A=C B=6, plus ADD commands until the FIFO is full:
  - `cmd_ready` stays low after DEPTH entries.
  - Popping one entry reopens `cmd_ready` the next cycle.
  - Results drain in order (F, 4, …).
- Assert `rst` during WAIT → no entry pushed; `res_valid`=0; `alu_*`=0; `op_count`=0.
- Issue 256 commands → `op_count` wraps to 0; no result is lost with `res_ready` held at 1.
